deslocador_barrel_pipe: RTL and testbench

//   Parametrised, pipelined barrel shifter. Successor to the 8-bit combinational left shifter.

---
 rtl/deslocador_barrel_pipe.sv | 134 +++++++++++++
 tb/tb_deslocador_barrel_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/deslocador_barrel_pipe.sv
// Pipelined barrel shifter: stage k applies a 2^k shift when its sh bit is set.
// Valid/ready on both sides; the ready chain is combinational so bubbles collapse.
module deslocador_barrel_pipe #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   sh,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] B,
  output logic             zero,
  output logic             busy
);

  localparam logic [1:0] ModeSll = 2'b00;
  localparam logic [1:0] ModeSrl = 2'b01;
  localparam logic [1:0] ModeSra = 2'b10;

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input int unsigned amt,
                                                  input logic [1:0] m,
                                                  input logic sign);
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] fill;
    fill = sign ? ~({WIDTH{1'b1}} >> amt) : '0;
    case (m)
      ModeSll: res = d << amt;
      ModeSrl: res = d >> amt;
      ModeSra: res = (d >> amt) | fill;
      default: res = (d << amt) | (d >> (WIDTH - amt));
    endcase
    return res;
  endfunction

  logic [SHW-1:0]   v_q, v_d;
  logic [WIDTH-1:0] data_q [SHW];
  logic [WIDTH-1:0] data_d [SHW];
  logic [SHW-1:0]   sh_q   [SHW];
  logic [SHW-1:0]   sh_d   [SHW];
  logic [1:0]       mode_q [SHW];
  logic [1:0]       mode_d [SHW];
  logic             sign_q [SHW];
  logic             sign_d [SHW];

  logic [SHW-1:0]   rdy;
  logic [SHW-1:0]   src_v;
  logic [WIDTH-1:0] src_data [SHW];
  logic [SHW-1:0]   src_sh   [SHW];
  logic [1:0]       src_mode [SHW];
  logic             src_sign [SHW];

  // Stage 0 is fed by the input port, every other stage by its predecessor.
  always_comb begin
    src_v       = '0;
    src_v[0]    = in_valid;
    src_data[0] = A;
    src_sh[0]   = sh;
    src_mode[0] = mode;
    src_sign[0] = A[WIDTH-1];
    for (int k = 1; k < int'(SHW); k++) begin
      src_v[k]    = v_q[k-1];
      src_data[k] = data_q[k-1];
      src_sh[k]   = sh_q[k-1];
      src_mode[k] = mode_q[k-1];
      src_sign[k] = sign_q[k-1];
    end
  end

  // rdy[k] = ~v[k] | rdy[k+1], unrolled as "not every stage from k up is full".
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    rdy      = '0;
    for (int k = int'(SHW) - 1; k >= 0; k--) begin
      all_full = all_full & v_q[k];
      rdy[k]   = ~all_full | out_ready;
    end
  end

  always_comb begin
    v_d = v_q;
    for (int k = 0; k < int'(SHW); k++) begin
      data_d[k] = data_q[k];
      sh_d[k]   = sh_q[k];
      mode_d[k] = mode_q[k];
      sign_d[k] = sign_q[k];
      if (rdy[k]) begin
        v_d[k] = src_v[k];
        if (src_v[k]) begin
          data_d[k] = src_sh[k][k] ? shift_step(src_data[k], 1 << k, src_mode[k], src_sign[k])
                                   : src_data[k];
          sh_d[k]   = src_sh[k];
          mode_d[k] = src_mode[k];
          sign_d[k] = src_sign[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < int'(SHW); k++) begin
        data_q[k] <= '0;
        sh_q[k]   <= '0;
        mode_q[k] <= '0;
        sign_q[k] <= 1'b0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < int'(SHW); k++) begin
        data_q[k] <= data_d[k];
        sh_q[k]   <= sh_d[k];
        mode_q[k] <= mode_d[k];
        sign_q[k] <= sign_d[k];
      end
    end
  end

  always_comb begin
    in_ready  = rdy[0];
    out_valid = v_q[SHW-1];
    B         = data_q[SHW-1];
    zero      = v_q[SHW-1] & ~|data_q[SHW-1];
    busy      = |v_q;
  end

endmodule

// File: tb/tb_deslocador_barrel_pipe.sv
// Bench for deslocador_barrel_pipe (WIDTH=8): scenario tasks plus a scoreboard
// that predicts every accepted operation and checks it when it leaves the pipe.
module tb_deslocador_barrel_pipe;

  localparam int LAT = 3;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [2:0] sh;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] B;
  logic       zero;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb [$];

  typedef struct packed {
    logic [7:0] a;
    logic [2:0] s;
    logic [1:0] m;
    logic [7:0] b;
  } vec_t;

  vec_t vecs [14] = '{
    '{8'h03, 3'd3, 2'd0, 8'h18},
    '{8'h90, 3'd2, 2'd2, 8'hE4},
    '{8'h90, 3'd2, 2'd1, 8'h24},
    '{8'h80, 3'd7, 2'd1, 8'h01},
    '{8'h81, 3'd1, 2'd3, 8'h03},
    '{8'hFF, 3'd0, 2'd0, 8'hFF},
    '{8'h80, 3'd1, 2'd0, 8'h00},
    '{8'hA5, 3'd0, 2'd1, 8'hA5},
    '{8'hA5, 3'd0, 2'd2, 8'hA5},
    '{8'hA5, 3'd0, 2'd3, 8'hA5},
    '{8'h81, 3'd7, 2'd3, 8'hC0},
    '{8'h70, 3'd3, 2'd2, 8'h0E},
    '{8'hB4, 3'd5, 2'd2, 8'hFD},
    '{8'h0F, 3'd6, 2'd3, 8'hC3}
  };

  deslocador_barrel_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .sh        (sh),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .B         (B),
    .zero      (zero),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] model(input logic [7:0] a, input logic [2:0] s,
                                       input logic [1:0] m);
    logic [7:0] r;
    case (m)
      2'd0:    r = a << s;
      2'd1:    r = a >> s;
      2'd2:    r = 8'($signed(a) >>> s);
      default: r = (s == 3'd0) ? a : ((a << s) | (a >> (8 - int'(s))));
    endcase
    return r;
  endfunction

  // Inputs change just after posedge, so the negedge sees what the next edge will transfer.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (!rst && in_valid && in_ready) sb.push_back(model(A, sh, mode));
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_output B=%h required no output", B);
      end else begin
        exp_b = sb.pop_front();
        if (B !== exp_b || zero !== (exp_b == 8'h00)) begin
          errors++;
          $display("FAIL sb_result B=%h zero=%b required B=%h zero=%b", B, zero, exp_b,
                   exp_b == 8'h00);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; sh = '0; mode = '0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (B !== 8'h00) begin errors++; $display("FAIL reset_B got %h want 00", B); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", zero); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_modes();
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      in_valid = 1'b1; A = vecs[i].a; sh = vecs[i].s; mode = vecs[i].m;
      @(posedge clk); #1;
      in_valid = 1'b0; A = 8'h5A; sh = 3'd5; mode = 2'd1;
      for (int e = 1; e < LAT; e++) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL modes_early v%0d edge %0d out_valid=%b want 0", i, e, out_valid);
        end
        @(posedge clk); #1;
      end
      checks++;
      if (out_valid !== 1'b1 || B !== vecs[i].b || zero !== (vecs[i].b == 8'h00)) begin
        errors++;
        $display("FAIL modes_result v%0d out_valid=%b B=%h zero=%b want 1 %h %b", i, out_valid,
                 B, zero, vecs[i].b, vecs[i].b == 8'h00);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL modes_one_cycle v%0d out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; A = 8'($urandom); sh = 3'($urandom); mode = 2'($urandom);
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", c, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== (c >= 2 && c <= 9)) begin
        errors++;
        $display("FAIL b2b_out_valid cycle %0d got %b want %b", c, out_valid, c >= 2 && c <= 9);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL b2b_drained pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_stall();
    logic [7:0] oa [4] = '{8'h01, 8'h80, 8'h80, 8'h81};
    logic [2:0] os [4] = '{3'd1, 3'd3, 3'd1, 3'd4};
    logic [1:0] om [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    int wait_cycles;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; A = oa[i]; sh = os[i]; mode = om[i];
      checks++;
      if (in_ready !== (i < 3)) begin
        errors++; $display("FAIL stall_in_ready op%0d got %b want %b", i + 1, in_ready, i < 3);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    // Full pipe: garbage on A/sh/mode must not get in while in_ready is low.
    for (int h = 0; h < 2; h++) begin
      A = 8'hEE; sh = 3'd2; mode = 2'd0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || B !== 8'h02 || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold out_valid=%b B=%h busy=%b in_ready=%b want 1 02 1 0",
                 out_valid, B, busy, in_ready);
      end
    end
    A = oa[3]; sh = os[3]; mode = om[3];
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release_in_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || B !== 8'h10) begin
      errors++; $display("FAIL stall_after_pop out_valid=%b B=%h want 1 10", out_valid, B);
    end
    wait_cycles = 0;
    while ((sb.size() != 0 || busy) && wait_cycles < 20) begin
      @(posedge clk); #1;
      wait_cycles++;
    end
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_drain pending=%0d busy=%b want 0 0", sb.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_valid = 1'b1; A = 8'h11; sh = 3'd1; mode = 2'd0;
    @(posedge clk); #1;
    A = 8'h22; sh = 3'd2; mode = 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || B !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_async out_valid=%b busy=%b in_ready=%b B=%h want 0 0 1 00",
               out_valid, busy, in_ready, B);
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_ghost cycle %0d out_valid=%b busy=%b want 0 0", c, out_valid, busy);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL final_scoreboard pending=%0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
